// File: rtl/ps2_scancode_filter.sv
// Purpose : resolves Set-2 E0/F0/E1 prefix sequences into clean make/break key events plus a held-key bitmap.
// Latency : key_valid/seq_error rise one cycle after the rx_valid byte that completes or breaks a sequence.
// Backpr. : none; every rx_valid byte is accepted, back-to-back bytes included.
// Ports   : clk, reset (async active-low); rx_data/rx_valid byte strobe in; clear_held sync clear of held;
//           key_code/key_ext/key_make/key_valid event out; held {enter,space,right,left,down,up};
//           seq_error one-cycle pulse on a malformed or abandoned sequence.
module ps2_scancode_filter #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear_held,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic       key_valid,
  output logic [5:0] held,
  output logic       seq_error
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GOT_E0   = 3'd1,
    GOT_F0   = 3'd2,
    GOT_E0F0 = 3'd3,
    SKIP     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    pause, pause_nxt;
  logic [CW-1:0] tcnt;
  logic          timeout_hit;
  logic          is_prefix, is_fake, is_nonkey;
  logic          ev, ev_ext, ev_make, err;
  logic [5:0]    key_mask;

  always_comb begin
    is_prefix = (rx_data == 8'hE0) || (rx_data == 8'hE1) || (rx_data == 8'hF0);
    // E0 12 / E0 59 are the fake-shift codes the keyboard wraps around extended keys
    is_fake   = (rx_data == 8'h12) || (rx_data == 8'h59);
    is_nonkey = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF);
  end

  // A byte arriving on the expiry cycle wins over the timeout
  assign timeout_hit = (state != IDLE) && !rx_valid && (tcnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    pause_nxt = pause;
    ev        = 1'b0;
    ev_ext    = 1'b0;
    ev_make   = 1'b0;
    err       = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0) begin
            state_nxt = GOT_E0;
          end else if (rx_data == 8'hF0) begin
            state_nxt = GOT_F0;
          end else if (rx_data == 8'hE1) begin
            state_nxt = SKIP;
            pause_nxt = 3'd7;
          end else if (!is_nonkey) begin
            ev      = 1'b1;
            ev_make = 1'b1;
          end
        end
        GOT_E0: begin
          if (rx_data == 8'hF0) begin
            state_nxt = GOT_E0F0;
          end else if (is_fake) begin
            state_nxt = IDLE;
          end else if (is_prefix) begin
            // stray E0/E1: flag it but keep waiting for the extended code
            err = 1'b1;
          end else begin
            ev        = 1'b1;
            ev_ext    = 1'b1;
            ev_make   = 1'b1;
            state_nxt = IDLE;
          end
        end
        GOT_F0: begin
          state_nxt = IDLE;
          if (is_prefix) begin
            err = 1'b1;
          end else begin
            ev = 1'b1;
          end
        end
        GOT_E0F0: begin
          state_nxt = IDLE;
          if (is_prefix) begin
            err = 1'b1;
          end else if (!is_fake) begin
            ev     = 1'b1;
            ev_ext = 1'b1;
          end
        end
        SKIP: begin
          pause_nxt = pause - 3'd1;
          if (pause <= 3'd1) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout_hit) begin
      err       = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_comb begin
    key_mask = 6'b000000;
    case ({ev_ext, rx_data})
      9'h01D, 9'h175: key_mask = 6'b000001;
      9'h01B, 9'h172: key_mask = 6'b000010;
      9'h01C, 9'h16B: key_mask = 6'b000100;
      9'h023, 9'h174: key_mask = 6'b001000;
      9'h029:         key_mask = 6'b010000;
      9'h05A, 9'h15A: key_mask = 6'b100000;
      default:        key_mask = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pause     <= 3'd0;
      tcnt      <= '0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_make  <= 1'b0;
      key_valid <= 1'b0;
      seq_error <= 1'b0;
      held      <= 6'b0;
    end else begin
      state     <= state_nxt;
      pause     <= pause_nxt;
      tcnt      <= (rx_valid || (state == IDLE) || timeout_hit) ? '0 : tcnt + CW'(1);
      key_valid <= ev;
      seq_error <= err;
      if (ev) begin
        key_code <= rx_data;
        key_ext  <= ev_ext;
        key_make <= ev_make;
      end
      // clear_held beats a same-cycle make
      if (clear_held) begin
        held <= 6'b0;
      end else if (ev) begin
        held <= ev_make ? (held | key_mask) : (held & ~key_mask);
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_filter.sv
module tb_ps2_scancode_filter;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clear_held = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_make, key_valid, seq_error;
  logic [5:0] held;

  always #5 clk = ~clk;

  ps2_scancode_filter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear_held(clear_held), .key_code(key_code), .key_ext(key_ext),
    .key_make(key_make), .key_valid(key_valid), .held(held), .seq_error(seq_error)
  );

  typedef struct {
    bit       is_err;
    bit [7:0] code;
    bit       ext;
    bit       make;
    bit [5:0] hld;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending prefix bytes, bytes still to skip, idle run length, key bitmap
  bit [7:0] pend[$];
  int       skip_left = 0;
  int       idle_run = 0;
  bit [5:0] m_held = 6'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit nonkey(bit [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF;
  endfunction

  function automatic bit prefix(bit [7:0] b);
    return b == 8'hE0 || b == 8'hE1 || b == 8'hF0;
  endfunction

  function automatic int bit_of(bit [7:0] c, bit e);
    if (!e) begin
      case (c)
        8'h1D: return 0; 8'h1B: return 1; 8'h1C: return 2;
        8'h23: return 3; 8'h29: return 4; 8'h5A: return 5;
        default: return -1;
      endcase
    end
    case (c)
      8'h75: return 0; 8'h72: return 1; 8'h6B: return 2;
      8'h74: return 3; 8'h5A: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_tick(bit v, bit [7:0] b, bit clr);
    bit ev, mk, ex, er, brk, fake;
    int k;
    ev = 0; mk = 0; ex = 0; er = 0;
    fake = (b == 8'h12) || (b == 8'h59);
    if (v) begin
      idle_run = 0;
    end else if (pend.size() > 0 || skip_left > 0) begin
      idle_run++;
      if (idle_run == T) begin
        er = 1; pend.delete(); skip_left = 0; idle_run = 0;
      end
    end else begin
      idle_run = 0;
    end
    if (v) begin
      if (skip_left > 0) begin
        skip_left--;
      end else if (pend.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
        else if (b == 8'hE1) skip_left = 7;
        else if (!nonkey(b)) begin ev = 1; mk = 1; end
      end else begin
        ex  = (pend[0] == 8'hE0);
        brk = (pend[pend.size()-1] == 8'hF0);
        if (!brk) begin
          if (b == 8'hF0) pend.push_back(b);
          else if (fake) pend.delete();
          else if (prefix(b)) er = 1;
          else begin ev = 1; mk = 1; pend.delete(); end
        end else begin
          if (ex && fake) pend.delete();
          else if (prefix(b)) begin er = 1; pend.delete(); end
          else begin ev = 1; mk = 0; pend.delete(); end
        end
      end
    end
    if (ev) begin
      k = bit_of(b, ex);
      if (k >= 0) m_held[k] = mk;
    end
    if (clr) m_held = 6'b0;
    if (ev || er) sbq.push_back('{er, b, ex, mk, m_held});
  endtask

  // One cycle of stimulus; returns at posedge+1 with that cycle's results registered
  task automatic tick(bit v, bit [7:0] b, bit clr);
    rx_valid   = v;
    rx_data    = v ? b : 8'($urandom);
    clear_held = clr;
    model_tick(v, b, clr);
    @(posedge clk); #1;
    rx_valid   = 1'b0;
    clear_held = 1'b0;
  endtask

  task automatic send(bit [7:0] b, int gap);
    tick(1'b1, b, 1'b0);
    repeat (gap) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_key_code"}, key_code, 8'h00);
    chk({tag, "_key_ext"}, key_ext, 0);
    chk({tag, "_key_make"}, key_make, 0);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_held"}, held, 6'b0);
    chk({tag, "_seq_error"}, seq_error, 0);
  endtask

  // Monitor: every strobe must match the next expected event
  always @(negedge clk) begin
    exp_t e;
    if (reset && (key_valid || seq_error)) begin
      chk("strobe_overlap", key_valid & seq_error, 0);
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: key_valid=%b seq_error=%b key_code=%h, no event expected",
                 key_valid, seq_error, key_code);
      end else begin
        e = sbq.pop_front();
        chk("event_kind_seq_error", seq_error, e.is_err);
        if (!e.is_err) begin
          chk("key_code", key_code, e.code);
          chk("key_ext", key_ext, e.ext);
          chk("key_make", key_make, e.make);
        end
        chk("held_at_event", held, e.hld);
      end
    end
  end

  bit [7:0] pool[20] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                         8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h14};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // make then break of up
    send(8'h1D, 0);
    chk("up_make_held", held, 6'b000001);
    send(8'hF0, 0); send(8'h1D, 2);
    chk("up_break_held", held, 6'b000000);

    // extended up
    send(8'hE0, 0); send(8'h75, 1);
    chk("ext_up_make_held", held, 6'b000001);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 2);
    chk("ext_up_break_held", held, 6'b000000);

    // two keys held, fake shift ignored
    send(8'h1D, 0); send(8'h23, 0); send(8'hE0, 0); send(8'h12, 2);
    chk("fake_shift_held", held, 6'b001001);
    send(8'hF0, 0); send(8'h23, 2);
    chk("right_release_held", held, 6'b000001);

    // Pause sequence swallowed, then space
    foreach (pool[i]) if (i == 0) begin
      send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
      send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 0);
    end
    send(8'h29, 2);
    chk("pause_then_space_held", held, 6'b010001);

    // timeout abandons a break prefix; next byte is a make
    send(8'hF0, T + 2);
    send(8'h1B, 2);
    chk("after_timeout_held", held, 6'b010011);
    // byte arriving on the last allowed cycle still completes the break
    send(8'hF0, T - 1);
    send(8'h1B, 2);
    chk("boundary_break_held", held, 6'b010001);

    // clear_held overrides a same-cycle make
    send(8'h5A, 1);
    tick(1'b1, 8'h1C, 1'b1);
    chk("clear_override_held", held, 6'b000000);
    repeat (2) tick(1'b0, 8'h00, 1'b0);

    // reset in the middle of a break prefix
    send(8'h29, 2);
    send(8'hF0, 0);
    reset = 1'b0;
    #2;
    check_reset_outputs("midseq_reset");
    pend.delete(); skip_left = 0; idle_run = 0; m_held = 6'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    send(8'h5A, 2);
    chk("post_reset_make_held", held, 6'b100000);

    // randomized stream
    for (int n = 0; n < 2500; n++) begin
      int r, gap;
      bit [7:0] b;
      r = $urandom_range(0, 15);
      gap = (r < 9) ? 0 : (r < 13) ? $urandom_range(1, 3) : (r == 13) ? T - 1 : (r == 14) ? T
                       : $urandom_range(4, T + 3);
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      tick(1'b1, b, $urandom_range(0, 19) == 0);
      for (int g = 0; g < gap; g++) tick(1'b0, 8'h00, $urandom_range(0, 49) == 0);
    end

    repeat (T + 4) tick(1'b0, 8'h00, 1'b0);
    chk("queue_drained", sbq.size(), 0);
    chk("final_held", held, m_held);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ps2_scancode_filter.md
Name: ps2_scancode_filter

Overview:
- Sits between the PS/2 byte receiver and the game-key decoder.
- Consumes raw Set-2 scancode bytes and resolves E0 (extended), F0 (break) and E1 (Pause) prefix sequences.
- Emits one clean make/break event per key action, plus a held-key bitmap for the six game keys, so downstream logic sees key releases instead of latching the last byte.

Parameters:
- TIMEOUT_CYCLES, 2500000, clk cycles a partial prefix sequence may wait for its next byte before being abandoned (50 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  byte from the PS/2 receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
- clear_held  input  1  synchronous clear of held[] (driven by the game's erase state).
- key_code  output  8  final scancode byte of the event.
- key_ext  output  1  event was E0-prefixed.
- key_make  output  1  1 = press/typematic repeat, 0 = release.
- key_valid  output  1  one-cycle event strobe; key_code/key_ext/key_make are valid in this cycle.
- held  output  6  {enter, space, right, left, down, up}; 1 while key is down.
- seq_error  output  1  one-cycle pulse on a malformed or timed-out sequence.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; timeout counter=0; pause counter=0.
  - key_code=8'h00; key_ext, key_make, key_valid, seq_error=0; held=6'b0.
  - Reset mid-sequence discards the partial sequence.
- Bytes are processed only in cycles with rx_valid=1.
- key_valid and seq_error are registered: they are high for exactly one cycle, the cycle after the rx_valid that completes or breaks a sequence. They are 0 in every other cycle.
- key_code, key_ext and key_make hold their last values between events.
- Non-key bytes are AA, FA, FE, EE, 00 and FF. In IDLE they are dropped: no event, no error.
- States and transitions:
  - IDLE:
    - E0 -> GOT_E0.
    - F0 -> GOT_F0.
    - E1 -> SKIP with pause counter=7.
    - non-key byte -> dropped, stay IDLE.
    - any other byte -> make event, ext=0.
  - GOT_E0:
    - F0 -> GOT_E0F0.
    - 12 or 59 (fake shift) -> dropped silently, go IDLE.
    - E0, E1 or F0-less prefix error -> seq_error, stay GOT_E0.
    - other byte -> make event, ext=1, go IDLE.
  - GOT_F0:
    - E0, E1 or F0 -> seq_error, go IDLE, byte dropped.
    - other byte -> break event, ext=0, go IDLE.
  - GOT_E0F0:
    - 12 or 59 -> dropped silently, go IDLE.
    - prefix byte -> seq_error, go IDLE.
    - other byte -> break event, ext=1, go IDLE.
  - SKIP:
    - Each byte decrements the pause counter; no events.
    - Go IDLE when the counter reaches 0.
    - This consumes the 7 bytes of the Pause sequence that follow E1.
- Timeout:
  - The counter clears on every rx_valid and while in IDLE.
  - In any non-IDLE state, when the counter reaches TIMEOUT_CYCLES-1: seq_error pulse, go IDLE.
  - If rx_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, the byte wins and the timeout does not fire.
- held[] bit mapping:
  - bit0 up: 1D, or E0 75.
  - bit1 down: 1B, or E0 72.
  - bit2 left: 1C, or E0 6B.
  - bit3 right: 23, or E0 74.
  - bit4 space: 29.
  - bit5 enter: 5A, or E0 5A.
  - A make event sets the bit and a break event clears it, on the same edge that raises key_valid.
  - Typematic repeats re-pulse key_valid with key_make=1; held stays 1.
- clear_held=1 clears all held bits and overrides a simultaneous make. key_valid events are still emitted.
- Multiple keys may be held at once; there is no exclusivity between bits.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.

Test Plan:
- rx 1D -> next cycle key_valid=1, key_code=1D, key_ext=0, key_make=1, held=6'b000001; then rx F0, 1D -> break event key_make=0, held=0.
- rx E0 75, then E0 F0 75 -> make then break events with key_ext=1, key_code=75; held[0] goes 1 then 0; no seq_error.
- Hold 1D and 23, then rx E0 12 -> held=6'b001001; fake shift produces no key_valid; then F0 23 -> held=6'b000001.
- rx E1 14 77 E1 F0 14 F0 77, then 29 -> zero events during the Pause sequence; one make event for 29, held[4]=1.
- TIMEOUT_CYCLES=16: rx F0, idle 16 cycles -> seq_error pulse at cycle 15, state IDLE; next rx 1B -> make event (not break).
- held=6'b100000 with clear_held=1 in the same cycle as the make strobe for 1C -> held=0, key_valid=1 still. Separately, assert reset while in GOT_F0 -> all outputs 0; next 5A -> make event.
